zzlab_axil_regs: RTL and testbench
==================================

# zzlab_axil_regs

Parametrised AXI4-Lite control-register slave. It generalises the fixed 6-bit/32-bit control port to configurable data width, register count and per-register read-only status inputs, with byte strobes, independent AW/W acceptance, error responses and per-register write pulses. It sits directly behind the `s_axi_control_*` port of a top-level wrapper and drives the core's configuration registers.

## Interface
- `C_S_AXI_CONTROL_DATA_WIDTH`, 32: bus and register width; legal values are 32 and 64.
- `C_S_AXI_CONTROL_ADDR_WIDTH`, 6: byte-address width.
- `C_S_AXI_CONTROL_WSTRB_WIDTH`, DATA_WIDTH/8: strobe width; derived, never overridden.
- `NUM_REGS`, 8: number of registers; 1 ≤ NUM_REGS ≤ 2^(ADDR_WIDTH − log2(WSTRB_WIDTH)).
- `RO_MASK`, 0: NUM_REGS-bit mask; bit i = 1 makes register i read-only, sourced from `reg_in`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axi_control_AWVALID` in 1, `s_axi_control_AWREADY` out 1, `s_axi_control_AWADDR` in ADDR_WIDTH: write-address channel.
- `s_axi_control_WVALID` in 1, `s_axi_control_WREADY` out 1, `s_axi_control_WDATA` in DATA_WIDTH, `s_axi_control_WSTRB` in WSTRB_WIDTH: write-data channel.
- `s_axi_control_BVALID` out 1, `s_axi_control_BREADY` in 1, `s_axi_control_BRESP` out 2: write response.
- `s_axi_control_ARVALID` in 1, `s_axi_control_ARREADY` out 1, `s_axi_control_ARADDR` in ADDR_WIDTH: read-address channel.
- `s_axi_control_RVALID` out 1, `s_axi_control_RREADY` in 1, `s_axi_control_RDATA` out DATA_WIDTH, `s_axi_control_RRESP` out 2: read data.
- `reg_out` out NUM_REGS×DATA_WIDTH: flattened register contents; register i is at slice [i·DW +: DW]. RO slices drive 0.
- `reg_in` in NUM_REGS×DATA_WIDTH: status values for RO registers; RW slices are ignored.
- `reg_wr_pulse` out NUM_REGS: one-cycle strobe per successfully written RW register.

## Operation
- Register index = ADDR[ADDR_WIDTH−1 : log2(WSTRB_WIDTH)]. Low address bits are ignored, so unaligned addresses act as aligned.
- Write path:
  - AW and W are captured independently into holding registers `aw_full` and `w_full`.
  - AWREADY = !aw_full && !BVALID. WREADY = !w_full && !BVALID.
  - At most one write is outstanding.
- Commit: on the first edge where aw_full && w_full are both high:
  - If the index is < NUM_REGS and the register is RW: each byte b is updated where WSTRB[b]=1; other bytes are kept. reg_wr_pulse[i] is set for that cycle only, even when WSTRB is 0. BRESP = 00 (OKAY).
  - If the index is ≥ NUM_REGS or the register is RO: nothing is written, no pulse, BRESP = 10 (SLVERR).
  - In all cases BVALID is set and both holding registers are cleared.
- B channel: BVALID and BRESP hold until BREADY; they clear on the edge where BVALID && BREADY.
- Read path: ARREADY = !RVALID. On the AR handshake edge:
  - RDATA is latched from the register (RW), from `reg_in` (RO), or is 0 (index out of range).
  - RRESP = 00, or 10 when out of range. RVALID is set.
  - RDATA, RRESP and RVALID hold until RREADY.
- Read and write are fully independent. A read latched on the same edge as a write commit to the same register returns the pre-write value.
- Reset: all registers, holding registers, BVALID, RVALID, RDATA, BRESP, RRESP and reg_wr_pulse go to 0; AWREADY, WREADY and ARREADY go to 1 on the cycle after reset. Any in-flight transaction is discarded without a response.

## Timing
- Write, AW and W in the same cycle (handshake edge T): commit at edge T+1; BVALID and reg_out update are visible after T+1; the pulse is high for exactly one cycle after T+1.
- Write, W arrives k cycles after AW: commit on the edge after the W handshake.
- Write throughput with BREADY held high: one write per 3 cycles.
- Read: RVALID is visible the cycle after the AR handshake. With RREADY held high, ARREADY reasserts the cycle after RVALID drops, giving one read per 2 cycles.
- Output timing: all outputs are registered except the READY signals, which are combinational from flops only. No path from any VALID input to any READY output.
- `reg_in` is sampled only on the AR handshake edge.

## Test plan
- Reset, then write 0xDEADBEEF with WSTRB=0xF to 0x08, then read 0x08: BRESP=00, reg_out slice 2 = 0xDEADBEEF, reg_wr_pulse=0x04 for one cycle, RDATA=0xDEADBEEF, RRESP=00.
- Byte strobe: write 0x11223344 with WSTRB=0x5 over 0xDEADBEEF at index 2 -> reg_out slice 2 = 0xDE22BE44.
- AW first, W 3 cycles later with BREADY low for 4 cycles: AWREADY=0 while aw_full; BVALID holds; no second write is accepted until the B handshake.
- Out-of-range and read-only: with RO_MASK=0x80 and reg_in slice 7 = 0xCAFE0001, a write to 0x1C gives BRESP=10 with no pulse; a read of 0x1C gives 0xCAFE0001 with RRESP=00. With ADDR_WIDTH=6 and NUM_REGS=8, reading 0x3C gives RDATA=0 and RRESP=10.
- Same-edge read/write to index 0 (old value 0x1, new value 0x2): RDATA=0x1; a following read returns 0x2.
- Assert rst for one cycle while BVALID=1 and RVALID=1: both are 0 after the reset edge, all READY signals are 1 one cycle later, and all reg_out slices are 0.
- Repeat the first scenario with DATA_WIDTH=64, NUM_REGS=4: write to 0x10 with WSTRB=0xFF.

Source files
------------

// File: rtl/zzlab_axil_regs.sv
// AXI4-Lite control-register slave: parametrised width/count, byte strobes,
// independent AW/W capture, SLVERR on out-of-range or read-only targets.
module zzlab_axil_regs #(
    parameter int C_S_AXI_CONTROL_DATA_WIDTH  = 32,
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH  = 6,
    parameter int C_S_AXI_CONTROL_WSTRB_WIDTH = C_S_AXI_CONTROL_DATA_WIDTH / 8,
    parameter int NUM_REGS                    = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            s_axi_control_AWVALID,
    output logic                                            s_axi_control_AWREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]           s_axi_control_AWADDR,
    input  logic                                            s_axi_control_WVALID,
    output logic                                            s_axi_control_WREADY,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]           s_axi_control_WDATA,
    input  logic [C_S_AXI_CONTROL_WSTRB_WIDTH-1:0]          s_axi_control_WSTRB,
    output logic                                            s_axi_control_BVALID,
    input  logic                                            s_axi_control_BREADY,
    output logic [1:0]                                      s_axi_control_BRESP,
    input  logic                                            s_axi_control_ARVALID,
    output logic                                            s_axi_control_ARREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]           s_axi_control_ARADDR,
    output logic                                            s_axi_control_RVALID,
    input  logic                                            s_axi_control_RREADY,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]           s_axi_control_RDATA,
    output logic [1:0]                                      s_axi_control_RRESP,
    output logic [NUM_REGS*C_S_AXI_CONTROL_DATA_WIDTH-1:0]  reg_out,
    input  logic [NUM_REGS*C_S_AXI_CONTROL_DATA_WIDTH-1:0]  reg_in,
    output logic [NUM_REGS-1:0]                             reg_wr_pulse
);

    localparam int DW   = C_S_AXI_CONTROL_DATA_WIDTH;
    localparam int AW   = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam int SW   = C_S_AXI_CONTROL_WSTRB_WIDTH;
    localparam int LSB  = $clog2(SW);
    localparam int IDXW = AW - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0]       regs_r [NUM_REGS];
    logic                aw_full_r;
    logic [IDXW-1:0]     aw_idx_r;
    logic                w_full_r;
    logic [DW-1:0]       w_data_r;
    logic [SW-1:0]       w_strb_r;
    logic                bvalid_r;
    logic [1:0]          bresp_r;
    logic                rvalid_r;
    logic [DW-1:0]       rdata_r;
    logic [1:0]          rresp_r;
    logic [NUM_REGS-1:0] wr_pulse_r;

    logic                aw_hs_s;
    logic                w_hs_s;
    logic                ar_hs_s;
    logic                commit_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    logic                wr_ok_s;
    logic [IDXW-1:0]     rd_idx_s;
    logic [DW-1:0]       rd_data_s;
    logic                rd_in_range_s;

    // Ready signals depend only on flops, never on the VALID inputs.
    assign s_axi_control_AWREADY = !aw_full_r && !bvalid_r;
    assign s_axi_control_WREADY  = !w_full_r && !bvalid_r;
    assign s_axi_control_ARREADY = !rvalid_r;

    assign aw_hs_s  = s_axi_control_AWVALID && s_axi_control_AWREADY;
    assign w_hs_s   = s_axi_control_WVALID && s_axi_control_WREADY;
    assign ar_hs_s  = s_axi_control_ARVALID && s_axi_control_ARREADY;
    assign commit_s = aw_full_r && w_full_r;
    assign rd_idx_s = s_axi_control_ARADDR[AW-1:LSB];

    // Decode the held write index into a one-hot select of writable registers.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel_s[i] = (32'(aw_idx_r) == i) && !RO_MASK[i];
        end
        wr_ok_s = |wr_sel_s;
    end

    // Read-data mux: RW from the register file, RO from reg_in, zero when out of range.
    always_comb begin
        rd_data_s     = '0;
        rd_in_range_s = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_in_range_s = rd_in_range_s | (32'(rd_idx_s) == i);
            rd_data_s     = rd_data_s |
                            ((32'(rd_idx_s) == i) ? (RO_MASK[i] ? reg_in[i*DW +: DW] : regs_r[i])
                                                  : '0);
        end
    end

    // AW and W holding registers, filled independently and drained by a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_r <= 1'b0;
            aw_idx_r  <= '0;
            w_full_r  <= 1'b0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
        end else begin
            if (aw_hs_s) begin
                aw_full_r <= 1'b1;
                aw_idx_r  <= s_axi_control_AWADDR[AW-1:LSB];
            end else if (commit_s) begin
                aw_full_r <= 1'b0;
            end
            if (w_hs_s) begin
                w_full_r <= 1'b1;
                w_data_r <= s_axi_control_WDATA;
                w_strb_r <= s_axi_control_WSTRB;
            end else if (commit_s) begin
                w_full_r <= 1'b0;
            end
        end
    end

    // Write response channel and the one-cycle write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= '0;
            if (commit_s) begin
                bvalid_r   <= 1'b1;
                bresp_r    <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
                wr_pulse_r <= wr_sel_s;
            end else if (bvalid_r && s_axi_control_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Register file with per-byte strobe merge; read-only slots are never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (commit_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < SW; b++) begin
                    if (wr_sel_s[i] && w_strb_r[b]) begin
                        regs_r[i][8*b +: 8] <= w_data_r[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read channel: data is captured on the AR handshake and held until RREADY.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && s_axi_control_RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
            assign reg_out[g*DW +: DW] = RO_MASK[g] ? '0 : regs_r[g];
        end
    endgenerate

    assign s_axi_control_BVALID = bvalid_r;
    assign s_axi_control_BRESP  = bresp_r;
    assign s_axi_control_RVALID = rvalid_r;
    assign s_axi_control_RDATA  = rdata_r;
    assign s_axi_control_RRESP  = rresp_r;
    assign reg_wr_pulse         = wr_pulse_r;

endmodule

// File: tb/tb_zzlab_axil_regs.sv
// Directed bench for zzlab_axil_regs: a 32-bit/8-register instance with
// register 7 read-only, plus a 64-bit/4-register instance.
module tb_zzlab_axil_regs;

    logic         clk_s;
    logic         rst_s;

    logic         awvalid_s, awready_s, wvalid_s, wready_s, bvalid_s, bready_s;
    logic         arvalid_s, arready_s, rvalid_s, rready_s;
    logic [5:0]   awaddr_s, araddr_s;
    logic [31:0]  wdata_s, rdata_s;
    logic [3:0]   wstrb_s;
    logic [1:0]   bresp_s, rresp_s;
    logic [255:0] reg_out_s, reg_in_s;
    logic [7:0]   pulse_s;

    logic         b_awvalid_s, b_awready_s, b_wvalid_s, b_wready_s, b_bvalid_s, b_bready_s;
    logic         b_arvalid_s, b_arready_s, b_rvalid_s, b_rready_s;
    logic [5:0]   b_awaddr_s, b_araddr_s;
    logic [63:0]  b_wdata_s, b_rdata_s;
    logic [7:0]   b_wstrb_s;
    logic [1:0]   b_bresp_s, b_rresp_s;
    logic [255:0] b_reg_out_s, b_reg_in_s;
    logic [3:0]   b_pulse_s;

    int checks_r;
    int errors_r;

    zzlab_axil_regs #(
        .NUM_REGS (8),
        .RO_MASK  (8'h80)
    ) dut_a (
        .clk                   (clk_s),
        .rst                   (rst_s),
        .s_axi_control_AWVALID (awvalid_s),
        .s_axi_control_AWREADY (awready_s),
        .s_axi_control_AWADDR  (awaddr_s),
        .s_axi_control_WVALID  (wvalid_s),
        .s_axi_control_WREADY  (wready_s),
        .s_axi_control_WDATA   (wdata_s),
        .s_axi_control_WSTRB   (wstrb_s),
        .s_axi_control_BVALID  (bvalid_s),
        .s_axi_control_BREADY  (bready_s),
        .s_axi_control_BRESP   (bresp_s),
        .s_axi_control_ARVALID (arvalid_s),
        .s_axi_control_ARREADY (arready_s),
        .s_axi_control_ARADDR  (araddr_s),
        .s_axi_control_RVALID  (rvalid_s),
        .s_axi_control_RREADY  (rready_s),
        .s_axi_control_RDATA   (rdata_s),
        .s_axi_control_RRESP   (rresp_s),
        .reg_out               (reg_out_s),
        .reg_in                (reg_in_s),
        .reg_wr_pulse          (pulse_s)
    );

    zzlab_axil_regs #(
        .C_S_AXI_CONTROL_DATA_WIDTH (64),
        .NUM_REGS                   (4)
    ) dut_b (
        .clk                   (clk_s),
        .rst                   (rst_s),
        .s_axi_control_AWVALID (b_awvalid_s),
        .s_axi_control_AWREADY (b_awready_s),
        .s_axi_control_AWADDR  (b_awaddr_s),
        .s_axi_control_WVALID  (b_wvalid_s),
        .s_axi_control_WREADY  (b_wready_s),
        .s_axi_control_WDATA   (b_wdata_s),
        .s_axi_control_WSTRB   (b_wstrb_s),
        .s_axi_control_BVALID  (b_bvalid_s),
        .s_axi_control_BREADY  (b_bready_s),
        .s_axi_control_BRESP   (b_bresp_s),
        .s_axi_control_ARVALID (b_arvalid_s),
        .s_axi_control_ARREADY (b_arready_s),
        .s_axi_control_ARADDR  (b_araddr_s),
        .s_axi_control_RVALID  (b_rvalid_s),
        .s_axi_control_RREADY  (b_rready_s),
        .s_axi_control_RDATA   (b_rdata_s),
        .s_axi_control_RRESP   (b_rresp_s),
        .reg_out               (b_reg_out_s),
        .reg_in                (b_reg_in_s),
        .reg_wr_pulse          (b_pulse_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    // Hard stop in case a wait loop is ever mis-bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pulse,
                             output logic [7:0] pulse_next);
        int n;
        @(negedge clk_s);
        awvalid_s = 1'b1; awaddr_s = addr;
        wvalid_s  = 1'b1; wdata_s  = data; wstrb_s = strb;
        @(negedge clk_s);
        awvalid_s = 1'b0; wvalid_s = 1'b0;
        n = 0;
        while (!bvalid_s && n < 16) begin
            @(negedge clk_s);
            n++;
        end
        check_eq("wr_latency", 64'(n), 64'd1);
        resp  = bresp_s;
        pulse = pulse_s;
        bready_s = 1'b1;
        @(negedge clk_s);
        bready_s   = 1'b0;
        pulse_next = pulse_s;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk_s);
        arvalid_s = 1'b1; araddr_s = addr;
        @(negedge clk_s);
        arvalid_s = 1'b0;
        n = 0;
        while (!rvalid_s && n < 16) begin
            @(negedge clk_s);
            n++;
        end
        check_eq("rd_latency", 64'(n), 64'd0);
        data = rdata_s;
        resp = rresp_s;
        rready_s = 1'b1;
        @(negedge clk_s);
        rready_s = 1'b0;
    endtask

    logic [1:0]  resp_v;
    logic [7:0]  pulse_v, pulse_next_v;
    logic [31:0] data_v;

    initial begin
        checks_r = 0;
        errors_r = 0;
        rst_s = 1'b1;
        {awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s} = 5'b00000;
        awaddr_s = 6'h00; araddr_s = 6'h00; wdata_s = 32'h0; wstrb_s = 4'h0;
        {b_awvalid_s, b_wvalid_s, b_bready_s, b_arvalid_s, b_rready_s} = 5'b00000;
        b_awaddr_s = 6'h00; b_araddr_s = 6'h00; b_wdata_s = 64'h0; b_wstrb_s = 8'h00;
        b_reg_in_s = {256{1'b1}};
        reg_in_s = 256'h0;
        reg_in_s[7*32 +: 32] = 32'hCAFE0001;
        reg_in_s[2*32 +: 32] = 32'hFFFFFFFF;
        repeat (2) @(negedge clk_s);
        rst_s = 1'b0;

        check_eq("rst_readies", 64'({awready_s, wready_s, arready_s}), 64'h7);
        check_eq("rst_valids", 64'({bvalid_s, rvalid_s}), 64'h0);
        check_eq("rst_reg_out", 64'(reg_out_s != 256'h0), 64'd0);
        check_eq("rst_pulse", 64'(pulse_s), 64'h0);

        // Full-word write then read of index 2
        axi_write(6'h08, 32'hDEADBEEF, 4'hF, resp_v, pulse_v, pulse_next_v);
        check_eq("wr1_bresp", 64'(resp_v), 64'h0);
        check_eq("wr1_pulse", 64'(pulse_v), 64'h04);
        check_eq("wr1_pulse_once", 64'(pulse_next_v), 64'h00);
        check_eq("wr1_reg_out", 64'(reg_out_s[2*32 +: 32]), 64'hDEADBEEF);
        axi_read(6'h08, data_v, resp_v);
        check_eq("rd1_data", 64'(data_v), 64'hDEADBEEF);
        check_eq("rd1_rresp", 64'(resp_v), 64'h0);

        // Byte strobes 0 and 2 only
        axi_write(6'h08, 32'h11223344, 4'h5, resp_v, pulse_v, pulse_next_v);
        check_eq("strb_reg_out", 64'(reg_out_s[2*32 +: 32]), 64'hDE22BE44);
        check_eq("strb_pulse", 64'(pulse_v), 64'h04);

        // AW leads W by three cycles; BREADY held low while a second write waits
        @(negedge clk_s);
        awvalid_s = 1'b1; awaddr_s = 6'h04;
        @(negedge clk_s);
        awvalid_s = 1'b0;
        check_eq("aw_full_awready", 64'(awready_s), 64'd0);
        check_eq("aw_only_wready", 64'(wready_s), 64'd1);
        repeat (2) @(negedge clk_s);
        wvalid_s = 1'b1; wdata_s = 32'h00000055; wstrb_s = 4'hF;
        @(negedge clk_s);
        wvalid_s = 1'b0;
        check_eq("late_w_no_early_b", 64'(bvalid_s), 64'd0);
        @(negedge clk_s);
        check_eq("late_w_bvalid", 64'(bvalid_s), 64'd1);
        check_eq("late_w_pulse", 64'(pulse_s), 64'h02);
        check_eq("late_w_reg_out", 64'(reg_out_s[1*32 +: 32]), 64'h00000055);
        awvalid_s = 1'b1; awaddr_s = 6'h0C;
        wvalid_s  = 1'b1; wdata_s  = 32'h00000099; wstrb_s = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_s);
            check_eq("b_hold_bvalid", 64'(bvalid_s), 64'd1);
            check_eq("b_hold_ready", 64'({awready_s, wready_s}), 64'h0);
            check_eq("b_hold_no_2nd", 64'(reg_out_s[3*32 +: 32]), 64'h0);
        end
        bready_s = 1'b1;
        @(negedge clk_s);
        bready_s = 1'b0;
        check_eq("b_hs_clears", 64'(bvalid_s), 64'd0);
        @(negedge clk_s);
        awvalid_s = 1'b0; wvalid_s = 1'b0;
        @(negedge clk_s);
        check_eq("second_bvalid", 64'(bvalid_s), 64'd1);
        check_eq("second_reg_out", 64'(reg_out_s[3*32 +: 32]), 64'h00000099);
        bready_s = 1'b1;
        @(negedge clk_s);
        bready_s = 1'b0;

        // Read-only and out-of-range targets
        axi_write(6'h1C, 32'h12345678, 4'hF, resp_v, pulse_v, pulse_next_v);
        check_eq("ro_wr_bresp", 64'(resp_v), 64'h2);
        check_eq("ro_wr_pulse", 64'(pulse_v), 64'h00);
        check_eq("ro_reg_out", 64'(reg_out_s[7*32 +: 32]), 64'h0);
        axi_read(6'h1C, data_v, resp_v);
        check_eq("ro_rd_data", 64'(data_v), 64'hCAFE0001);
        check_eq("ro_rd_rresp", 64'(resp_v), 64'h0);
        axi_read(6'h3C, data_v, resp_v);
        check_eq("oor_rd_data", 64'(data_v), 64'h0);
        check_eq("oor_rd_rresp", 64'(resp_v), 64'h2);
        axi_write(6'h3C, 32'h0000FFFF, 4'hF, resp_v, pulse_v, pulse_next_v);
        check_eq("oor_wr_bresp", 64'(resp_v), 64'h2);
        check_eq("oor_wr_pulse", 64'(pulse_v), 64'h00);
        axi_read(6'h0A, data_v, resp_v);
        check_eq("unaligned_rd", 64'(data_v), 64'hDE22BE44);

        // Read latched on the same edge as a write commit sees the old value
        axi_write(6'h00, 32'h00000001, 4'hF, resp_v, pulse_v, pulse_next_v);
        @(negedge clk_s);
        awvalid_s = 1'b1; awaddr_s = 6'h00;
        wvalid_s  = 1'b1; wdata_s  = 32'h00000002; wstrb_s = 4'hF;
        @(negedge clk_s);
        awvalid_s = 1'b0; wvalid_s = 1'b0;
        arvalid_s = 1'b1; araddr_s = 6'h00;
        @(negedge clk_s);
        arvalid_s = 1'b0;
        check_eq("same_edge_rvalid", 64'(rvalid_s), 64'd1);
        check_eq("same_edge_old", 64'(rdata_s), 64'h1);
        check_eq("same_edge_bvalid", 64'(bvalid_s), 64'd1);
        rready_s = 1'b1; bready_s = 1'b1;
        @(negedge clk_s);
        rready_s = 1'b0; bready_s = 1'b0;
        axi_read(6'h00, data_v, resp_v);
        check_eq("same_edge_new", 64'(data_v), 64'h2);

        // Reset while both responses are pending
        @(negedge clk_s);
        awvalid_s = 1'b1; awaddr_s = 6'h04; wvalid_s = 1'b1; wdata_s = 32'h3; wstrb_s = 4'hF;
        arvalid_s = 1'b1; araddr_s = 6'h08;
        @(negedge clk_s);
        awvalid_s = 1'b0; wvalid_s = 1'b0; arvalid_s = 1'b0;
        @(negedge clk_s);
        check_eq("pre_rst_valids", 64'({bvalid_s, rvalid_s}), 64'h3);
        rst_s = 1'b1;
        @(negedge clk_s);
        rst_s = 1'b0;
        check_eq("post_rst_valids", 64'({bvalid_s, rvalid_s}), 64'h0);
        check_eq("post_rst_reg_out", 64'(reg_out_s != 256'h0), 64'd0);
        check_eq("post_rst_rdata", 64'(rdata_s), 64'h0);
        @(negedge clk_s);
        check_eq("post_rst_readies", 64'({awready_s, wready_s, arready_s}), 64'h7);

        // 64-bit instance: index 2 lives at byte address 0x10
        @(negedge clk_s);
        b_awvalid_s = 1'b1; b_awaddr_s = 6'h10;
        b_wvalid_s  = 1'b1; b_wdata_s  = 64'h0123456789ABCDEF; b_wstrb_s = 8'hFF;
        @(negedge clk_s);
        b_awvalid_s = 1'b0; b_wvalid_s = 1'b0;
        @(negedge clk_s);
        check_eq("w64_bvalid", 64'(b_bvalid_s), 64'd1);
        check_eq("w64_bresp", 64'(b_bresp_s), 64'h0);
        check_eq("w64_pulse", 64'(b_pulse_s), 64'h4);
        check_eq("w64_reg_out", b_reg_out_s[2*64 +: 64], 64'h0123456789ABCDEF);
        b_bready_s = 1'b1;
        @(negedge clk_s);
        b_bready_s = 1'b0;
        check_eq("w64_pulse_once", 64'(b_pulse_s), 64'h0);
        b_arvalid_s = 1'b1; b_araddr_s = 6'h10;
        @(negedge clk_s);
        b_arvalid_s = 1'b0;
        check_eq("r64_rvalid", 64'(b_rvalid_s), 64'd1);
        check_eq("r64_data", b_rdata_s, 64'h0123456789ABCDEF);
        check_eq("r64_rresp", 64'(b_rresp_s), 64'h0);
        b_rready_s = 1'b1;
        @(negedge clk_s);
        b_rready_s = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
